muldiv_arbiter: RTL and testbench
=================================

Name: muldiv_arbiter

Overview:
- Schedules the single shared multiply/divide unit between the two issue-queue requesters (slot 1, slot 2).
- Grants at most one request per transaction, with round-robin priority.
- Sequences the unit through start, compute and result-hold phases, then presents the HI/LO result to the writeback stage.
- Aborts cleanly on pipeline flush.

Parameters:
- DATA_W, 32, operand and result width.
- ROB_W, 4, ROB index width.
- PHY_W, 6, physical register address width.
- MUL_LAT, 3, fixed multiply latency in cycles from md_start; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; abort everything in flight
- req1_valid  in  1  slot 1 request
- req1_op  in  4  op code: 0 MUL, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU
- req1_rob_idx  in  ROB_W  ROB index of the request
- req1_phy_dest  in  PHY_W  physical destination register
- req1_a, req1_b  in  DATA_W  operands
- req2_valid, req2_op, req2_rob_idx, req2_phy_dest, req2_a, req2_b  in  as slot 1, for slot 2
- grant1, grant2  out  1  request accepted this cycle (combinational)
- md_start  out  1  one-cycle start pulse to the unit
- md_abort  out  1  one-cycle abort pulse to the unit
- md_op  out  4  latched op
- md_a, md_b  out  DATA_W  latched operands
- md_done  in  1  divide complete; ignored for multiply ops
- md_hi, md_lo  in  DATA_W  unit result
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts the result
- wb_rob_idx  out  ROB_W  ROB index of the result
- wb_phy_dest  out  PHY_W  destination of the result
- wb_hi, wb_lo  out  DATA_W  captured result
- busy  out  1  state is not IDLE

Behaviour:
- States and encodings: IDLE, START, COMPUTE, HOLD.
- Reset: state IDLE; rr_ptr = 0 (slot 1 has priority); all outputs 0; latched registers cleared.
- Grant in IDLE with flush = 0:
  - only one slot requesting: that slot is granted;
  - both slots requesting: the slot selected by rr_ptr is granted, and rr_ptr then points at the other slot;
  - a single-requester grant leaves rr_ptr unchanged.
- No grant in any other state, or while flush = 1. grant1 and grant2 are never both 1.
- Grant cycle actions: latch op, operands, rob_idx and phy_dest; next state START.
- START (1 cycle):
  - md_start = 1 with the latched md_op, md_a, md_b;
  - for ops other than DIV/DIVU, load lat_cnt = MUL_LAT - 1;
  - next state COMPUTE.
- COMPUTE, multiply ops (everything except DIV/DIVU):
  - lat_cnt decrements each cycle;
  - when lat_cnt == 0, capture md_hi/md_lo into wb_hi/wb_lo and go to HOLD.
  - With MUL_LAT = 1, COMPUTE lasts one cycle.
- COMPUTE, DIV/DIVU: wait for md_done = 1, then capture the result and go to HOLD. There is no timeout.
- HOLD:
  - wb_valid = 1; wb_* outputs are stable until the handshake;
  - on wb_valid && wb_ready, go to IDLE.
  - The next grant is possible in the cycle after the handshake, not in the same cycle.
- Latency: a multiply granted in cycle T gives wb_valid = 1 in cycle T + 2 + MUL_LAT.
- flush:
  - In any state, flush takes priority over every other transition: next state IDLE, wb_valid drops the next cycle, and the captured result is discarded.
  - md_abort pulses for one cycle if the flush arrives in START or COMPUTE.
  - rr_ptr is not changed by flush.
- Reset mid-operation: same as flush, except md_abort is not pulsed and rr_ptr returns to 0.
- md_done arriving outside COMPUTE/DIV is ignored.

Optional Feature:
- Macro: MULDIV_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - perf_busy_cycles  out  32: counts cycles with busy = 1;
  - perf_conflict_cycles  out  32: counts cycles with req1_valid && req2_valid and no grant to one of them (both stalled counts once).
- Both counters saturate at 0xFFFFFFFF and clear on reset only, not on flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single multiply: req1 MULT, a = 7, b = 6, MUL_LAT = 3, wb_ready = 1; unit returns hi = 0, lo = 42 -> grant1 at T, md_start at T+1, wb_valid at T+5 with wb_lo = 42 and the req1 rob_idx/phy_dest.
- Contention: req1 and req2 both valid from reset -> grant1 first. After its writeback, with both still requesting -> grant2, then grant1, alternating.
- Divide: req2 DIVU 100/7; md_done asserted 20 cycles after md_start with hi = 2, lo = 14 -> wb_valid the cycle after md_done, wb_hi = 2, wb_lo = 14.
- Backpressure: wb_ready = 0 for 5 cycles in HOLD -> wb_* held constant, no grant to a pending req1, grant one cycle after the handshake.
- Flush in COMPUTE during a divide -> md_abort pulses once, state IDLE next cycle, no wb_valid, and a new request is granted the following cycle.
- Simultaneous flush and request in IDLE -> no grant. With MULDIV_PERF_CNT_EN defined, perf_busy_cycles equals the summed BUSY cycles over the run.

Source files
------------

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter and sequencer for the shared multiply/divide unit.
// Optional perf counters: define MULDIV_PERF_CNT_EN.
module muldiv_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4,
  parameter int PHY_W   = 6,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req1_valid,
  input  logic [3:0]        req1_op,
  input  logic [ROB_W-1:0]  req1_rob_idx,
  input  logic [PHY_W-1:0]  req1_phy_dest,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req2_valid,
  input  logic [3:0]        req2_op,
  input  logic [ROB_W-1:0]  req2_rob_idx,
  input  logic [PHY_W-1:0]  req2_phy_dest,
  input  logic [DATA_W-1:0] req2_a,
  input  logic [DATA_W-1:0] req2_b,
  output logic              grant1,
  output logic              grant2,
  output logic              md_start,
  output logic              md_abort,
  output logic [3:0]        md_op,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ROB_W-1:0]  wb_rob_idx,
  output logic [PHY_W-1:0]  wb_phy_dest,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
`ifdef MULDIV_PERF_CNT_EN
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_conflict_cycles,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_COMPUTE = 2'd2,
    S_HOLD    = 2'd3
  } state_e;

  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] LAT_M1  = 4'(MUL_LAT - 1);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ROB_W-1:0]  rob_q, rob_d;
  logic [PHY_W-1:0]  phy_q, phy_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              is_div;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rob_d    = rob_q;
    phy_d    = phy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    grant1   = 1'b0;
    grant2   = 1'b0;
    md_abort = 1'b0;

    if (state_q == S_IDLE && !flush && !reset) begin
      if (req1_valid && req2_valid) begin
        grant1 = !rr_q;
        grant2 = rr_q;
        rr_d   = !rr_q;
      end else begin
        grant1 = req1_valid;
        grant2 = req2_valid;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant1) begin
          op_d    = req1_op;
          a_d     = req1_a;
          b_d     = req1_b;
          rob_d   = req1_rob_idx;
          phy_d   = req1_phy_dest;
          state_d = S_START;
        end else if (grant2) begin
          op_d    = req2_op;
          a_d     = req2_a;
          b_d     = req2_b;
          rob_d   = req2_rob_idx;
          phy_d   = req2_phy_dest;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!is_div) cnt_d = LAT_M1;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (is_div ? md_done : (cnt_q == 4'd0)) begin
          hi_d    = md_hi;
          lo_d    = md_lo;
          state_d = S_HOLD;
        end else if (!is_div) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over every transition and drops any captured result.
    if (flush) begin
      state_d  = S_IDLE;
      hi_d     = '0;
      lo_d     = '0;
      md_abort = !reset &&
                 (state_q == S_START || state_q == S_COMPUTE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rob_q   <= '0;
      phy_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rob_q   <= rob_d;
      phy_q   <= phy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign md_start    = (state_q == S_START);
  assign md_op       = op_q;
  assign md_a        = a_q;
  assign md_b        = b_q;
  assign wb_valid    = (state_q == S_HOLD);
  assign wb_rob_idx  = rob_q;
  assign wb_phy_dest = phy_q;
  assign wb_hi       = hi_q;
  assign wb_lo       = lo_q;

`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] pbusy_q, pbusy_d;
  logic [31:0] pconf_q, pconf_d;

  // Saturating; only reset clears them, flush does not.
  always_comb begin
    pbusy_d = pbusy_q;
    pconf_d = pconf_q;
    if (busy && pbusy_q != '1) pbusy_d = pbusy_q + 32'd1;
    if (req1_valid && req2_valid && pconf_q != '1)
      pconf_d = pconf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pbusy_q <= '0;
      pconf_q <= '0;
    end else begin
      pbusy_q <= pbusy_d;
      pconf_q <= pconf_d;
    end
  end

  assign perf_busy_cycles     = pbusy_q;
  assign perf_conflict_cycles = pconf_q;
`endif

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed self-checking bench for muldiv_arbiter.
// Covers grant, latency, divide, backpressure and flush paths.
module tb_muldiv_arbiter;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req1_valid, req2_valid;
  logic [3:0]  req1_op, req2_op;
  logic [3:0]  req1_rob_idx, req2_rob_idx;
  logic [5:0]  req1_phy_dest, req2_phy_dest;
  logic [31:0] req1_a, req1_b, req2_a, req2_b;
  logic        grant1, grant2, md_start, md_abort;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_done;
  logic [31:0] md_hi, md_lo;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rob_idx;
  logic [5:0]  wb_phy_dest;
  logic [31:0] wb_hi, wb_lo;
  logic        busy;
`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] perf_busy_cycles, perf_conflict_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req1_valid(req1_valid), .req1_op(req1_op),
    .req1_rob_idx(req1_rob_idx), .req1_phy_dest(req1_phy_dest),
    .req1_a(req1_a), .req1_b(req1_b),
    .req2_valid(req2_valid), .req2_op(req2_op),
    .req2_rob_idx(req2_rob_idx), .req2_phy_dest(req2_phy_dest),
    .req2_a(req2_a), .req2_b(req2_b),
    .grant1(grant1), .grant2(grant2),
    .md_start(md_start), .md_abort(md_abort),
    .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rob_idx(wb_rob_idx), .wb_phy_dest(wb_phy_dest),
    .wb_hi(wb_hi), .wb_lo(wb_lo),
`ifdef MULDIV_PERF_CNT_EN
    .perf_busy_cycles(perf_busy_cycles),
    .perf_conflict_cycles(perf_conflict_cycles),
`endif
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    req1_valid = 0; req1_op = 0; req1_rob_idx = 0; req1_phy_dest = 0;
    req1_a = 0; req1_b = 0;
    req2_valid = 0; req2_op = 0; req2_rob_idx = 0; req2_phy_dest = 0;
    req2_a = 0; req2_b = 0;
    md_done = 0; md_hi = 0; md_lo = 0; wb_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, wb_valid, md_start, md_abort, grant1, grant2} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000",
               {busy, wb_valid, md_start, md_abort, grant1, grant2});
    end
    checks++;
    if ({md_op, md_a, md_b, wb_hi, wb_lo} !== '0) begin
      errors++;
      $display("FAIL reset_data: op=%0d a=%0d b=%0d hi=%0d lo=%0d want 0",
               md_op, md_a, md_b, wb_hi, wb_lo);
    end
`ifdef MULDIV_PERF_CNT_EN
    checks++;
    if (perf_busy_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d want 0", perf_busy_cycles);
    end
`endif
  endtask

  task automatic test_single_mul();
    req1_valid = 1; req1_op = 4'd1; req1_a = 7; req1_b = 6;
    req1_rob_idx = 4'd3; req1_phy_dest = 6'd9;
    md_hi = 0; md_lo = 42; wb_ready = 1;
    #1;
    checks++;
    if ({grant1, grant2} !== 2'b10) begin
      errors++;
      $display("FAIL mul_grant: got %b want 10", {grant1, grant2});
    end
    step();
    req1_valid = 0;
    #1;
    checks++;
    if (md_start !== 1'b1 || md_op !== 4'd1 || md_a !== 32'd7 || md_b !== 32'd6) begin
      errors++;
      $display("FAIL mul_start: start=%b op=%0d a=%0d b=%0d want 1 1 7 6",
               md_start, md_op, md_a, md_b);
    end
    step(); step(); step();
    checks++;
    if (wb_valid !== 1'b0 || md_start !== 1'b0) begin
      errors++;
      $display("FAIL mul_early: wb_valid=%b start=%b want 0 0", wb_valid, md_start);
    end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_lo !== 32'd42 || wb_hi !== 32'd0 ||
        wb_rob_idx !== 4'd3 || wb_phy_dest !== 6'd9) begin
      errors++;
      $display("FAIL mul_wb: v=%b hi=%0d lo=%0d rob=%0d phy=%0d want 1 0 42 3 9",
               wb_valid, wb_hi, wb_lo, wb_rob_idx, wb_phy_dest);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_idle: busy=%b want 0", busy);
    end
`ifdef MULDIV_PERF_CNT_EN
    checks++;
    if (perf_busy_cycles !== 32'd5) begin
      errors++;
      $display("FAIL perf_busy: got %0d want 5", perf_busy_cycles);
    end
`endif
  endtask

  task automatic test_contention();
    req1_valid = 1; req1_op = 0; req1_rob_idx = 4'd1;
    req2_valid = 1; req2_op = 0; req2_rob_idx = 4'd2;
    md_lo = 5; wb_ready = 1;
    #1;
    checks++;
    if ({grant1, grant2} !== 2'b10) begin
      errors++;
      $display("FAIL cont_g1: got %b want 10", {grant1, grant2});
    end
    step(); step(); step();
    checks++;
    if ({grant1, grant2} !== 2'b00) begin
      errors++;
      $display("FAIL cont_busy_grant: got %b want 00", {grant1, grant2});
    end
    step(); step();
    checks++;
    if (wb_valid !== 1'b1 || wb_rob_idx !== 4'd1) begin
      errors++;
      $display("FAIL cont_wb1: v=%b rob=%0d want 1 1", wb_valid, wb_rob_idx);
    end
    step();
    checks++;
    if ({grant1, grant2} !== 2'b01) begin
      errors++;
      $display("FAIL cont_g2: got %b want 01", {grant1, grant2});
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (wb_valid !== 1'b1 || wb_rob_idx !== 4'd2) begin
      errors++;
      $display("FAIL cont_wb2: v=%b rob=%0d want 1 2", wb_valid, wb_rob_idx);
    end
    step();
    checks++;
    if ({grant1, grant2} !== 2'b10) begin
      errors++;
      $display("FAIL cont_g3: got %b want 10", {grant1, grant2});
    end
    step();
    req1_valid = 0; req2_valid = 0;
    drain();
  endtask

  task automatic test_divide();
    req2_valid = 1; req2_op = 4'd4; req2_a = 100; req2_b = 7;
    req2_rob_idx = 4'd5; req2_phy_dest = 6'd12;
    md_hi = 0; md_lo = 0; md_done = 0; wb_ready = 1;
    #1;
    checks++;
    if ({grant1, grant2} !== 2'b01) begin
      errors++;
      $display("FAIL div_grant: got %b want 01", {grant1, grant2});
    end
    step();
    req2_valid = 0;
    #1;
    checks++;
    if (md_start !== 1'b1 || md_op !== 4'd4 || md_a !== 32'd100 || md_b !== 32'd7) begin
      errors++;
      $display("FAIL div_start: start=%b op=%0d a=%0d b=%0d want 1 4 100 7",
               md_start, md_op, md_a, md_b);
    end
    for (int i = 0; i < 19; i++) step();
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL div_wait: v=%b busy=%b want 0 1", wb_valid, busy);
    end
    step();
    md_done = 1; md_hi = 2; md_lo = 14;
    step();
    md_done = 0; md_hi = 0; md_lo = 0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_hi !== 32'd2 || wb_lo !== 32'd14 ||
        wb_rob_idx !== 4'd5 || wb_phy_dest !== 6'd12) begin
      errors++;
      $display("FAIL div_wb: v=%b hi=%0d lo=%0d rob=%0d phy=%0d want 1 2 14 5 12",
               wb_valid, wb_hi, wb_lo, wb_rob_idx, wb_phy_dest);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL div_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    req1_valid = 1; req1_op = 0; req1_a = 3; req1_b = 5;
    req1_rob_idx = 4'd7; req1_phy_dest = 6'd20;
    md_hi = 0; md_lo = 15; wb_ready = 0;
    #1;
    checks++;
    if (grant1 !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant: got %b want 1", grant1);
    end
    for (int i = 0; i < 5; i++) step();
    md_lo = 99;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_lo !== 32'd15 || wb_rob_idx !== 4'd7 ||
          grant1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b lo=%0d rob=%0d g1=%b want 1 15 7 0",
                 i, wb_valid, wb_lo, wb_rob_idx, grant1);
      end
      step();
    end
    wb_ready = 1;
    #1;
    checks++;
    if (grant1 !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hs_cycle: g1=%b v=%b want 0 1", grant1, wb_valid);
    end
    step();
    checks++;
    if (grant1 !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_regrant: g1=%b busy=%b want 1 0", grant1, busy);
    end
    step();
    req1_valid = 0;
    drain();
  endtask

  task automatic test_flush_div();
    req1_valid = 1; req1_op = 4'd3; req1_a = 9; req1_b = 2;
    req1_rob_idx = 4'd4; md_done = 0; wb_ready = 1;
    #1;
    checks++;
    if (grant1 !== 1'b1) begin
      errors++;
      $display("FAIL fl_grant: got %b want 1", grant1);
    end
    step();
    req1_valid = 0;
    step(); step();
    flush = 1; req2_valid = 1; req2_op = 0; req2_rob_idx = 4'd6;
    #1;
    checks++;
    if (md_abort !== 1'b1 || grant2 !== 1'b0) begin
      errors++;
      $display("FAIL fl_abort: abort=%b g2=%b want 1 0", md_abort, grant2);
    end
    step();
    flush = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || wb_valid !== 1'b0 || md_abort !== 1'b0 ||
        grant2 !== 1'b1) begin
      errors++;
      $display("FAIL fl_after: busy=%b v=%b abort=%b g2=%b want 0 0 0 1",
               busy, wb_valid, md_abort, grant2);
    end
    step();
    req2_valid = 0;
    drain();
  endtask

  task automatic test_flush_idle();
    flush = 1; req1_valid = 1; req1_op = 0;
    #1;
    checks++;
    if ({grant1, grant2} !== 2'b00) begin
      errors++;
      $display("FAIL fli_grant: got %b want 00", {grant1, grant2});
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fli_busy: busy=%b want 0", busy);
    end
    flush = 0;
    #1;
    checks++;
    if (grant1 !== 1'b1) begin
      errors++;
      $display("FAIL fli_regrant: got %b want 1", grant1);
    end
    step();
    req1_valid = 0;
    drain();
  endtask

  task automatic test_reset_midop();
    req2_valid = 1; req2_op = 0;
    #1;
    checks++;
    if (grant2 !== 1'b1) begin
      errors++;
      $display("FAIL rst_grant: got %b want 1", grant2);
    end
    step();
    req2_valid = 0;
    step();
    reset = 1;
    #1;
    checks++;
    if (md_abort !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: got %b want 0", md_abort);
    end
    step();
    reset = 0;
    req1_valid = 1; req2_valid = 1;
    #1;
    checks++;
    if (busy !== 1'b0 || {grant1, grant2} !== 2'b10) begin
      errors++;
      $display("FAIL rst_rr: busy=%b g=%b want 0 10", busy, {grant1, grant2});
    end
    step();
    req1_valid = 0; req2_valid = 0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_contention();
    test_divide();
    test_backpressure();
    test_flush_div();
    test_flush_idle();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
